// File: rtl/qbus_dma_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qbus_dma_arb: Q-bus DMA arbiter between the CPU control chip and NREQ     |
// | fixed-priority DMA masters, with SACK supervision and CPU fairness hold.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module qbus_dma_arb #(
   parameter int NREQ     = 4,
   parameter int SACK_TO  = 16,
   parameter int HOLD_MAX = 8
) (
   input  logic            pin_clk_p,
   input  logic            pin_sr,
   input  logic            pin_breq,
   input  logic            pin_syns,
   input  logic            pin_synr,
   input  logic [NREQ-1:0] pin_dmr,
   input  logic [NREQ-1:0] pin_sack,
   output logic [NREQ-1:0] pin_dmg,
   output logic            pin_bbusy,
   output logic            cpu_cyc,
   output logic            sack_err
);

   localparam int CMAX = (SACK_TO > HOLD_MAX) ? SACK_TO : HOLD_MAX;
   localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
   localparam int WW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CW-1:0] SACK_LAST = CW'(SACK_TO - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
   localparam logic [CW-1:0] CNT_SAT   = '1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CPU   = 3'd1,
      ST_GRANT = 3'd2,
      ST_DMA   = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   win_q, win_d, low_idx;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            sack_err_q, sack_err_d;

   // Lowest set index wins: scan downward so the last hit is the smallest.
   always_comb begin
      low_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (pin_dmr[i]) low_idx = WW'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      cnt_d      = cnt_q;
      sack_err_d = 1'b0;
      cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (pin_syns) begin
               state_d = ST_CPU;
            end else if (|pin_sack) begin
               state_d = ST_IDLE;
            end else if (|pin_dmr) begin
               state_d = ST_GRANT;
               win_d   = low_idx;
               cnt_d   = '0;
            end
         end
         ST_CPU: begin
            if (pin_synr) state_d = ST_IDLE;
         end
         ST_GRANT: begin
            cnt_d = cnt_inc;
            if (pin_sack[win_q]) begin
               state_d = ST_DMA;
            end else if (!pin_dmr[win_q]) begin
               state_d = ST_IDLE;
            end else if (cnt_q == SACK_LAST) begin
               state_d    = ST_IDLE;
               sack_err_d = 1'b1;
            end
         end
         ST_DMA: begin
            if (!pin_sack[win_q]) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         ST_HOLD: begin
            // The bus is released here so a pending CPU cycle can start first.
            cnt_d = cnt_inc;
            if (pin_syns) begin
               state_d = ST_CPU;
            end else if (!pin_breq || (cnt_q == HOLD_LAST)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pin_clk_p) begin
      if (pin_sr) begin
         state_q    <= ST_IDLE;
         win_q      <= '0;
         cnt_q      <= '0;
         sack_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         cnt_q      <= cnt_d;
         sack_err_q <= sack_err_d;
      end
   end

   always_comb begin
      pin_dmg   = (state_q == ST_GRANT) ? (NREQ'(1) << win_q) : '0;
      pin_bbusy = (state_q == ST_GRANT) || (state_q == ST_DMA);
      cpu_cyc   = (state_q == ST_CPU);
      sack_err  = sack_err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_qbus_dma_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qbus_dma_arb: directed self-checking bench for qbus_dma_arb.          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_qbus_dma_arb;

   logic       pin_clk_p = 1'b0;
   logic       pin_sr    = 1'b0;
   logic       pin_breq  = 1'b0;
   logic       pin_syns  = 1'b0;
   logic       pin_synr  = 1'b0;
   logic [3:0] pin_dmr   = 4'b0;
   logic [3:0] pin_sack  = 4'b0;
   logic [3:0] pin_dmg;
   logic       pin_bbusy;
   logic       cpu_cyc;
   logic       sack_err;

   int checks = 0;
   int errors = 0;

   qbus_dma_arb #(.NREQ(4), .SACK_TO(16), .HOLD_MAX(8)) dut (
      .pin_clk_p (pin_clk_p),
      .pin_sr    (pin_sr),
      .pin_breq  (pin_breq),
      .pin_syns  (pin_syns),
      .pin_synr  (pin_synr),
      .pin_dmr   (pin_dmr),
      .pin_sack  (pin_sack),
      .pin_dmg   (pin_dmg),
      .pin_bbusy (pin_bbusy),
      .cpu_cyc   (cpu_cyc),
      .sack_err  (sack_err)
   );

   always #5 pin_clk_p = ~pin_clk_p;

   // Advance n rising edges, then settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge pin_clk_p);
      #1;
   endtask

   task automatic test_reset;
      pin_sr  = 1'b1;
      pin_dmr = 4'hF;
      step(2);
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL reset_dmg: got %b expected 0000", pin_dmg); end
      checks++; if (pin_bbusy !== 1'b0) begin errors++; $display("FAIL reset_bbusy: got %b expected 0", pin_bbusy); end
      checks++; if (sack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sack_err); end
      checks++; if (cpu_cyc !== 1'b0) begin errors++; $display("FAIL reset_cpu: got %b expected 0", cpu_cyc); end
      pin_sr  = 1'b0;
      pin_dmr = 4'b0;
      step(1);
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL reset_idle_dmg: got %b expected 0000", pin_dmg); end
   endtask

   task automatic test_priority;
      pin_dmr = 4'b1010;
      step(1);
      checks++; if (pin_dmg !== 4'b0010) begin errors++; $display("FAIL prio_dmg: got %b expected 0010", pin_dmg); end
      checks++; if (pin_bbusy !== 1'b1) begin errors++; $display("FAIL prio_bbusy_grant: got %b expected 1", pin_bbusy); end
      pin_dmr = 4'b1011;
      step(1);
      checks++; if (pin_dmg !== 4'b0010) begin errors++; $display("FAIL prio_no_preempt: got %b expected 0010", pin_dmg); end
      pin_sack = 4'b0010;
      step(1);
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL prio_dma_dmg: got %b expected 0000", pin_dmg); end
      checks++; if (pin_bbusy !== 1'b1) begin errors++; $display("FAIL prio_dma_bbusy: got %b expected 1", pin_bbusy); end
      pin_sack = 4'b0011;
      step(1);
      checks++; if (pin_bbusy !== 1'b1) begin errors++; $display("FAIL prio_dma_hold_sack: got %b expected 1", pin_bbusy); end
      pin_dmr  = 4'b0000;
      pin_sack = 4'b0001;
      step(1);
      checks++; if (pin_bbusy !== 1'b0) begin errors++; $display("FAIL prio_hold_bbusy: got %b expected 0", pin_bbusy); end
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL prio_hold_dmg: got %b expected 0000", pin_dmg); end
      pin_sack = 4'b0000;
      step(2);
   endtask

   task automatic test_tie_fairness;
      pin_syns = 1'b1;
      pin_dmr  = 4'b0001;
      step(1);
      pin_syns = 1'b0;
      checks++; if (cpu_cyc !== 1'b1) begin errors++; $display("FAIL tie_cpu: got %b expected 1", cpu_cyc); end
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL tie_dmg: got %b expected 0000", pin_dmg); end
      step(2);
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL tie_dmg_cpu_hold: got %b expected 0000", pin_dmg); end
      pin_synr = 1'b1;
      step(1);
      pin_synr = 1'b0;
      checks++; if (cpu_cyc !== 1'b0) begin errors++; $display("FAIL tie_cpu_end: got %b expected 0", cpu_cyc); end
      step(1);
      checks++; if (pin_dmg !== 4'b0001) begin errors++; $display("FAIL tie_grant_after_cpu: got %b expected 0001", pin_dmg); end
      pin_sack = 4'b0001;
      step(1);
      checks++; if (pin_bbusy !== 1'b1) begin errors++; $display("FAIL fair_dma_bbusy: got %b expected 1", pin_bbusy); end
      pin_breq = 1'b1;
      pin_sack = 4'b0000;
      step(1);
      checks++; if (pin_bbusy !== 1'b0) begin errors++; $display("FAIL fair_hold_bbusy: got %b expected 0", pin_bbusy); end
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL fair_hold_dmg: got %b expected 0000", pin_dmg); end
      pin_syns = 1'b1;
      step(1);
      pin_syns = 1'b0;
      checks++; if (cpu_cyc !== 1'b1) begin errors++; $display("FAIL fair_cpu_first: got %b expected 1", cpu_cyc); end
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL fair_cpu_dmg: got %b expected 0000", pin_dmg); end
      pin_synr = 1'b1;
      step(1);
      pin_synr = 1'b0;
      step(1);
      checks++; if (pin_dmg !== 4'b0001) begin errors++; $display("FAIL fair_regrant: got %b expected 0001", pin_dmg); end
      pin_dmr  = 4'b0000;
      pin_breq = 1'b0;
      step(1);
   endtask

   task automatic test_hold_timeout;
      pin_dmr = 4'b0010;
      step(1);
      pin_sack = 4'b0010;
      step(1);
      pin_breq = 1'b1;
      pin_sack = 4'b0000;
      step(1);
      checks++; if (pin_bbusy !== 1'b0) begin errors++; $display("FAIL hold_enter_bbusy: got %b expected 0", pin_bbusy); end
      step(8);
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL hold_exit_idle_dmg: got %b expected 0000", pin_dmg); end
      step(1);
      checks++; if (pin_dmg !== 4'b0010) begin errors++; $display("FAIL hold_exit_regrant: got %b expected 0010", pin_dmg); end
      pin_dmr  = 4'b0000;
      pin_breq = 1'b0;
      step(1);
   endtask

   task automatic test_timeout;
      pin_dmr = 4'b0100;
      step(1);
      checks++; if (pin_dmg !== 4'b0100) begin errors++; $display("FAIL to_grant: got %b expected 0100", pin_dmg); end
      step(15);
      checks++; if (pin_dmg !== 4'b0100) begin errors++; $display("FAIL to_grant_16th: got %b expected 0100", pin_dmg); end
      checks++; if (sack_err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b expected 0", sack_err); end
      step(1);
      checks++; if (sack_err !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b expected 1", sack_err); end
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL to_dmg_drop: got %b expected 0000", pin_dmg); end
      step(1);
      checks++; if (sack_err !== 1'b0) begin errors++; $display("FAIL to_err_one_cycle: got %b expected 0", sack_err); end
      checks++; if (pin_dmg !== 4'b0100) begin errors++; $display("FAIL to_regrant: got %b expected 0100", pin_dmg); end
      pin_dmr = 4'b0000;
      step(1);
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL to_withdraw_dmg: got %b expected 0000", pin_dmg); end
   endtask

   task automatic test_withdraw;
      pin_dmr = 4'b1000;
      step(1);
      checks++; if (pin_dmg !== 4'b1000) begin errors++; $display("FAIL wd_grant: got %b expected 1000", pin_dmg); end
      step(2);
      pin_dmr = 4'b0000;
      step(1);
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL wd_dmg: got %b expected 0000", pin_dmg); end
      checks++; if (pin_bbusy !== 1'b0) begin errors++; $display("FAIL wd_bbusy: got %b expected 0", pin_bbusy); end
      checks++; if (sack_err !== 1'b0) begin errors++; $display("FAIL wd_err: got %b expected 0", sack_err); end
      step(1);
      checks++; if (sack_err !== 1'b0) begin errors++; $display("FAIL wd_err_late: got %b expected 0", sack_err); end
   endtask

   task automatic test_reset_mid_dma;
      pin_dmr = 4'b0001;
      step(1);
      pin_sack = 4'b0001;
      step(1);
      checks++; if (pin_bbusy !== 1'b1) begin errors++; $display("FAIL rst_dma_bbusy: got %b expected 1", pin_bbusy); end
      pin_sr = 1'b1;
      step(1);
      pin_sr = 1'b0;
      checks++; if (pin_bbusy !== 1'b0) begin errors++; $display("FAIL rst_abort_bbusy: got %b expected 0", pin_bbusy); end
      step(3);
      checks++; if (pin_dmg !== 4'b0000) begin errors++; $display("FAIL rst_stale_sack_dmg: got %b expected 0000", pin_dmg); end
      checks++; if (pin_bbusy !== 1'b0) begin errors++; $display("FAIL rst_stale_sack_bbusy: got %b expected 0", pin_bbusy); end
      pin_sack = 4'b0000;
      step(1);
      checks++; if (pin_dmg !== 4'b0001) begin errors++; $display("FAIL rst_grant_after_sack: got %b expected 0001", pin_dmg); end
      pin_dmr = 4'b0000;
      step(1);
   endtask

   task automatic test_syns_synr_same;
      pin_syns = 1'b1;
      pin_synr = 1'b1;
      step(1);
      pin_syns = 1'b0;
      pin_synr = 1'b0;
      checks++; if (cpu_cyc !== 1'b1) begin errors++; $display("FAIL ss_enter_cpu: got %b expected 1", cpu_cyc); end
      step(2);
      checks++; if (cpu_cyc !== 1'b1) begin errors++; $display("FAIL ss_stay_cpu: got %b expected 1", cpu_cyc); end
      pin_synr = 1'b1;
      step(1);
      pin_synr = 1'b0;
      checks++; if (cpu_cyc !== 1'b0) begin errors++; $display("FAIL ss_leave_cpu: got %b expected 0", cpu_cyc); end
   endtask

   initial begin
      step(1);
      test_reset;
      test_priority;
      test_tie_fairness;
      test_hold_timeout;
      test_timeout;
      test_withdraw;
      test_reset_mid_dma;
      test_syns_synr_same;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
